irq_sched: RTL
==============

IRQ_SCHED -- requirements
Module: irq_sched

Interface
REQ-001 Parameter NUM_SRC, default 4: number of interrupt sources; legal range 2..16.
REQ-002 Parameter ID_W, default 2: width of the source index; SHALL equal clog2(NUM_SRC).
REQ-003 Parameter EDGE_MODE, default 1: 1 = rising-edge-sensitive sources, 0 = level-sensitive sources.
REQ-004 Parameter IRQ_ACTIVE_STATE, default 1: active level of irq.
REQ-005 ACLK  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 ARESET  in  1  reset; synchronous and active-high.
REQ-007 src  in  NUM_SRC  raw interrupt sources from PL logic, synchronous to ACLK.
REQ-008 glb_en  in  1  global interrupt enable.
REQ-009 intr_en  in  NUM_SRC  per-source enable.
REQ-010 ack_valid  in  1  one-cycle acknowledge strobe from the register interface.
REQ-011 ack_id  in  ID_W  index of the source being acknowledged; qualified by ack_valid.
REQ-012 irq  out  1  interrupt line to the PS.
REQ-013 irq_id  out  ID_W  index of the source currently being serviced.
REQ-014 pending  out  NUM_SRC  pending status, readable by software.
REQ-015 busy  out  1  high in the ASSERT and GAP states.
REQ-016 ack_err  out  1  one-cycle pulse on a rejected acknowledge.

Function
REQ-017 Edge mode: src SHALL be registered each cycle. pending[i] SHALL set on the cycle after src[i] samples 1 while its previous sample was 0 and intr_en[i]=1.
REQ-018 Edge mode: pending[i] SHALL clear on an accepted ack for source i. If a set and a clear for the same bit occur in the same cycle, the set SHALL win.
REQ-019 Level mode: pending SHALL equal the registered (src & intr_en), with no latching; an ack SHALL NOT modify pending.
REQ-020 Clearing intr_en[i] SHALL NOT clear an already-set pending[i]; the bit SHALL stay masked from arbitration until intr_en[i] returns to 1.
REQ-021 The FSM SHALL have exactly three states: IDLE, ASSERT and GAP.
REQ-022 IDLE -> ASSERT when glb_en=1 and (pending & intr_en) is non-zero. On this transition the winner index SHALL be latched into irq_id.
REQ-023 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_SRC. last_grant SHALL update only on an accepted ack.
REQ-024 irq SHALL be registered and equal IRQ_ACTIVE_STATE exactly while the state is ASSERT; otherwise it SHALL be the inverse level.
REQ-025 Edge-mode latency from an idle FSM: src edge sampled at cycle t -> pending at t+1 -> irq active at t+2.
REQ-026 In ASSERT, an ack is accepted when ack_valid=1 and ack_id equals irq_id. On acceptance:
- the pending bit clears per REQ-018;
- last_grant is set to irq_id;
- the FSM moves to GAP, so irq goes inactive the next cycle.
REQ-027 In ASSERT, ack_valid with a mismatched ack_id SHALL pulse ack_err for one cycle and leave the state, pending and irq unchanged.
REQ-028 ack_valid received in IDLE or GAP SHALL pulse ack_err and have no other effect.
REQ-029 In ASSERT, glb_en=0 or intr_en[irq_id]=0 SHALL return the FSM to IDLE with irq inactive the next cycle. pending SHALL be retained and last_grant SHALL be unchanged.
REQ-030 GAP SHALL last exactly one cycle, then the FSM SHALL go to IDLE. This guarantees a minimum irq-inactive time of 2 cycles between services.
REQ-031 irq_id SHALL hold its value outside ASSERT until the next grant.

Reset
REQ-032 When ARESET=1 at a clock edge, all registers SHALL be forced to reset values on that edge:
- state = IDLE;
- irq = inactive level;
- irq_id = 0;
- pending = 0;
- last_grant = NUM_SRC-1, so source 0 wins first;
- the src history register = 0;
- busy = 0;
- ack_err = 0.
REQ-033 Reset asserted mid-ASSERT SHALL drop irq on the same edge and discard all pending events. A src held high through reset SHALL NOT be seen as an edge after release until it falls and rises again.

Verification
REQ-034 Single source: glb_en=1, intr_en=4'b0001, src[0] 0->1 at t -> pending=4'b0001 at t+1 and irq=1, irq_id=0 at t+2. Ack with id 0 -> irq=0 and pending=0 on the next cycle.
REQ-035 Round-robin: src[3:0] all rise in the same cycle with all enabled -> services occur in order 0,1,2,3, each with irq low for exactly 2 cycles between services. A fresh src[0] edge during service 1 is serviced after 3.
REQ-036 Wrong ack: during service of id 2, apply ack_valid with ack_id=1 -> ack_err pulses once, irq stays 1 and pending[2] stays 1. A following ack with id 2 completes the service.
REQ-037 Global disable: drop glb_en while irq=1 -> irq=0 the next cycle with pending unchanged. Re-enable -> the same irq_id is re-asserted 2 cycles later.
REQ-038 Set/clear collision: src[1] re-rises in the cycle the ack for id 1 is accepted -> pending[1] remains 1 and id 1 is serviced again after GAP.
REQ-039 Reset mid-operation: assert ARESET for 1 cycle during ASSERT with src[0] held high -> irq=0 and pending=0 after the edge, and no new irq occurs until src[0] toggles low then high.

Source files
------------

// File: rtl/irq_sched_if.sv
// Interrupt scheduler bus: raw sources, enables and acknowledge in; irq line, serviced id and status out.
// The master drives sources/enables/acks, the slave (the scheduler) drives irq and status.
interface irq_sched_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
);
  logic [NUM_SRC-1:0] src;
  logic               glb_en;
  logic [NUM_SRC-1:0] intr_en;
  logic               ack_valid;
  logic [ID_W-1:0]    ack_id;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] pending;
  logic               busy;
  logic               ack_err;

  modport master (
    output src, glb_en, intr_en, ack_valid, ack_id,
    input  irq, irq_id, pending, busy, ack_err
  );

  modport slave (
    input  src, glb_en, intr_en, ack_valid, ack_id,
    output irq, irq_id, pending, busy, ack_err
  );
endinterface

// File: rtl/irq_sched.sv
// Round-robin interrupt scheduler: src edge -> pending next cycle -> irq the cycle after; one-cycle GAP after each ack.
// No backpressure: acks are accepted only in ASSERT with a matching id, anything else pulses ack_err.
module irq_sched #(
  parameter int NUM_SRC          = 4,
  parameter int ID_W             = 2,
  parameter int EDGE_MODE        = 1,
  parameter int IRQ_ACTIVE_STATE = 1
) (
  input logic         ACLK,
  input logic         ARESET,
  irq_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  localparam logic            IRQ_ON   = (IRQ_ACTIVE_STATE != 0);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_SRC - 1);

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] src_q, pending_q, pending_nxt, masked, rise, clr;
  logic               hist_vld;
  logic [ID_W-1:0]    irq_id_q, last_grant, winner;
  logic               win_vld, accept, irq_q, busy_q, ack_err_q;

  assign masked = pending_q & bus.intr_en;
  assign accept = (state == ASSERT) && bus.ack_valid && (bus.ack_id == irq_id_q);

  // hist_vld blocks the first sample after reset so a source held high through reset is not an edge
  assign rise = bus.src & ~src_q & bus.intr_en & {NUM_SRC{hist_vld}};

  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!win_vld && masked[idx[ID_W-1:0]]) begin
        win_vld = 1'b1;
        winner  = idx[ID_W-1:0];
      end
    end
  end

  // A new edge on the bit being acked wins over the clear
  always_comb begin
    clr = '0;
    if (accept) clr[irq_id_q] = 1'b1;
    if (EDGE_MODE != 0) pending_nxt = (pending_q & ~clr) | rise;
    else                pending_nxt = bus.src & bus.intr_en;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.glb_en && win_vld) state_nxt = ASSERT;
      ASSERT: begin
        if (accept)                                        state_nxt = GAP;
        else if (!bus.glb_en || !bus.intr_en[irq_id_q])    state_nxt = IDLE;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      irq_q      <= ~IRQ_ON;
      irq_id_q   <= '0;
      pending_q  <= '0;
      last_grant <= LAST_RST;
      src_q      <= '0;
      hist_vld   <= 1'b0;
      busy_q     <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      irq_q     <= (state_nxt == ASSERT) ? IRQ_ON : ~IRQ_ON;
      busy_q    <= (state_nxt != IDLE);
      pending_q <= pending_nxt;
      src_q     <= bus.src;
      hist_vld  <= 1'b1;
      ack_err_q <= bus.ack_valid && !accept;
      if (state == IDLE && state_nxt == ASSERT) irq_id_q <= winner;
      if (accept) last_grant <= irq_id_q;
    end
  end

  assign bus.irq     = irq_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.pending = pending_q;
  assign bus.busy    = busy_q;
  assign bus.ack_err = ack_err_q;
endmodule
